// File: rtl/eater_pkg.sv
// Shared definitions for the eater_core accumulator machine: opcodes, the
// microcode state enum and instruction-field extraction helpers.
package eater_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [3:0] {
    S_HALT,
    S_FETCH_A,
    S_FETCH_R,
    S_FETCH_I,
    S_DECODE,
    S_MEM_R,
    S_MEM_L,
    S_ALU,
    S_MEM_W,
    S_OUT_WAIT
  } state_e;

  // Opcode lives in the top nibble of the word, whatever the data width.
  function automatic logic [3:0] opcode_of(input logic [63:0] word, input int data_w);
    return word[data_w-1 -: 4];
  endfunction

  function automatic logic [15:0] operand_of(input logic [63:0] word, input int addr_w);
    logic [63:0] mask;
    mask = (64'd1 << addr_w) - 64'd1;
    return 16'(word & mask);
  endfunction

endpackage

// File: rtl/eater_ram.sv
// Single-port synchronous RAM, read-before-write.
module eater_ram #(
  parameter int    DATA_W  = 8,
  parameter int    ADDR_W  = 4,
  parameter string RAM_HEX = ""
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[addr_i];
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eater_core.sv
// SAP-style accumulator core with hardwired microcode, halted-only load port
// and a valid/ready output stream. Define EATER_CORE_STEP_EN for step_i.
module eater_core
  import eater_pkg::*;
#(
  parameter int    DATA_W   = 8,  // must be >= ADDR_W+4
  parameter int    ADDR_W   = 4,
  parameter int    RESET_PC = 0,
  parameter string RAM_HEX  = ""
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              run_i,
`ifdef EATER_CORE_STEP_EN
  input  logic              step_i,
`endif
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              halted_o,
  output logic [ADDR_W-1:0] pc_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic              c_q, c_d, z_q, z_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              run_q;
  logic              stop_fetch;
  logic              core_we;

  logic [3:0]        op;
  logic [ADDR_W-1:0] opd;
  logic              is_sub;
  logic [DATA_W:0]   alu_sum;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              ram_we;

  assign op     = opcode_of(64'(ir_q), DATA_W);
  assign opd    = ADDR_W'(operand_of(64'(ir_q), ADDR_W));
  assign is_sub = (op == OP_SUB);
  // SUB is A + ~B + 1, so the carry-out is NOT borrow.
  assign alu_sum = {1'b0, a_q} + {1'b0, (is_sub ? ~b_q : b_q)} + (DATA_W+1)'(is_sub);

`ifdef EATER_CORE_STEP_EN
  logic step_q, step_mode_q, step_mode_d;
  assign stop_fetch = ~run_i | step_mode_q;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      step_q      <= step_i;
      step_mode_q <= step_mode_d;
    end
  end
`else
  assign stop_fetch = ~run_i;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mar_d       = mar_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    core_we     = 1'b0;
`ifdef EATER_CORE_STEP_EN
    step_mode_d = step_mode_q;
`endif
    case (state_q)
      S_HALT: begin
`ifdef EATER_CORE_STEP_EN
        step_mode_d = 1'b0;
        if (run_i && !run_q) state_d = S_FETCH_A;
        else if (step_i && !step_q) begin
          state_d     = S_FETCH_A;
          step_mode_d = 1'b1;
        end
`else
        if (run_i && !run_q) state_d = S_FETCH_A;
`endif
      end
      S_FETCH_A: begin
        if (stop_fetch) state_d = S_HALT;
        else begin
          mar_d   = pc_q;
          state_d = S_FETCH_R;
        end
      end
      S_FETCH_R: state_d = S_FETCH_I;
      S_FETCH_I: begin
        ir_d    = ram_q;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH_A;
        case (op)
          OP_NOP: ;
          OP_LDI: a_d = DATA_W'(opd);
          OP_JMP: pc_d = opd;
          OP_JC:  if (c_q) pc_d = opd;
          OP_JZ:  if (z_q) pc_d = opd;
          OP_HLT: state_d = S_HALT;
          OP_OUT: begin
            out_data_d  = a_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT_WAIT;
          end
          OP_LDA, OP_ADD, OP_SUB: begin
            mar_d   = opd;
            state_d = S_MEM_R;
          end
          OP_STA: begin
            mar_d   = opd;
            state_d = S_MEM_W;
          end
          default: ;
        endcase
      end
      S_MEM_R: state_d = S_MEM_L;
      S_MEM_L: begin
        if (op == OP_LDA) begin
          a_d     = ram_q;
          state_d = S_FETCH_A;
        end else begin
          b_d     = ram_q;
          state_d = S_ALU;
        end
      end
      S_ALU: begin
        a_d     = alu_sum[DATA_W-1:0];
        c_d     = alu_sum[DATA_W];
        z_d     = (alu_sum[DATA_W-1:0] == '0);
        state_d = S_FETCH_A;
      end
      S_MEM_W: begin
        core_we = 1'b1;
        state_d = S_FETCH_A;
      end
      S_OUT_WAIT: begin
        // The handshake cycle doubles as the next FETCH_A, so an unstalled
        // OUT costs four cycles.
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (stop_fetch) state_d = S_HALT;
          else begin
            mar_d   = pc_q;
            state_d = S_FETCH_R;
          end
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= S_HALT;
      pc_q        <= ADDR_W'(RESET_PC);
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      run_q       <= run_i;
    end
  end

  // Load port owns the RAM port while halted; STA owns it otherwise.
  assign ram_addr  = halted_o ? load_addr_i : mar_q;
  assign ram_wdata = halted_o ? load_data_i : a_q;
  assign ram_we    = (halted_o & load_we_i) | core_we;

  eater_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RAM_HEX(RAM_HEX)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_q)
  );

  assign halted_o    = (state_q == S_HALT);
  assign pc_o        = pc_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_eater_core.sv
// Self-checking bench for eater_core: directed and random programs checked
// against an instruction-level reference model.
module tb_eater_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       load_we = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       halted;
  logic [3:0] pc;
`ifdef EATER_CORE_STEP_EN
  logic       step = 1'b0;
`endif

  logic        w_run = 1'b0;
  logic        w_we = 1'b0;
  logic [7:0]  w_addr = '0;
  logic [11:0] w_wdata = '0;
  logic [11:0] w_out;
  logic        w_valid;
  logic        w_halted;
  logic [7:0]  w_pc;

  int n_chk = 0;
  int n_err = 0;

  int mram [16];
  int m_a, m_pc;
  bit m_c, m_z;
  int exp_q[$];
  int got[$];

  always #5 clk = ~clk;

  eater_core #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0), .RAM_HEX("")) dut (
    .clk_i(clk), .reset(reset), .run_i(run),
`ifdef EATER_CORE_STEP_EN
    .step_i(step),
`endif
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .halted_o(halted), .pc_o(pc)
  );

  eater_core #(.DATA_W(12), .ADDR_W(8), .RESET_PC(0), .RAM_HEX("")) dut_w (
    .clk_i(clk), .reset(reset), .run_i(w_run),
`ifdef EATER_CORE_STEP_EN
    .step_i(1'b0),
`endif
    .load_we_i(w_we), .load_addr_i(w_addr), .load_data_i(w_wdata),
    .out_data_o(w_out), .out_valid_o(w_valid), .out_ready_i(1'b1),
    .halted_o(w_halted), .pc_o(w_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int enc(input int op, input int opd);
    return (op << 4) | (opd & 15);
  endfunction

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; load_we = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    m_a = 0; m_pc = 0; m_c = 0; m_z = 0;
  endtask

  task automatic load_image();
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 4'(i); load_data = 8'(mram[i]);
      tick();
    end
    load_we = 1'b0;
  endtask

  // Instruction-level model: executes the ISA on mram, collects OUT words
  // and returns the unstalled cycle count up to halted_o.
  task automatic model_run(output int cyc);
    int w, op, opd, r, b;
    bit done;
    exp_q.delete(); cyc = 0; done = 0;
    for (int s = 0; s < 64 && !done; s++) begin
      w = mram[m_pc]; m_pc = (m_pc + 1) % 16;
      op = w >> 4; opd = w & 15; cyc += 4;
      case (op)
        1: begin m_a = mram[opd]; cyc += 2; end
        2, 3: begin
          b = mram[opd];
          r = (op == 2) ? m_a + b : m_a + (255 - b) + 1;
          m_c = (r > 255); m_a = r % 256; m_z = (m_a == 0); cyc += 3;
        end
        4: begin mram[opd] = m_a; cyc += 1; end
        5: m_a = opd;
        6: m_pc = opd;
        7: if (m_c) m_pc = opd;
        8: if (m_z) m_pc = opd;
        14: exp_q.push_back(m_a);
        15: done = 1;
        default: ;
      endcase
    end
  endtask

  task automatic run_prog(input bit rand_ready, input bit hold_we, output int ncyc, output bit tmo);
    got.delete();
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    run = 1'b1;
    tick();
    if (hold_we) begin load_we = 1'b1; load_addr = 4'd15; load_data = 8'hAA; end
    ncyc = 0; tmo = 1;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && out_ready) got.push_back(int'(out_data));
      tick(); ncyc++;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      if (halted) begin tmo = 0; break; end
    end
    load_we = 1'b0; run = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic cmp_outs(input string name);
    n_chk++;
    if (got.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s out count: got %0d want %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_chk++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s out[%0d]: got %0d want %0d", name, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0;
    repeat (3) tick();
    n_chk++; if (halted !== 1'b1) begin n_err++; $display("FAIL reset halted: got %b want 1", halted); end
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", out_valid); end
    n_chk++; if (pc !== 4'd0) begin n_err++; $display("FAIL reset pc: got %0d want 0", pc); end
    n_chk++; if (out_data !== 8'd0) begin n_err++; $display("FAIL reset out_data: got %0d want 0", out_data); end
    reset = 1'b0;
    repeat (3) tick();
    n_chk++; if (halted !== 1'b1) begin n_err++; $display("FAIL idle halted: got %b want 1", halted); end
  endtask

  task automatic test_arith();
    int mc, nc; bit tmo;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(1, 14); mram[1] = enc(2, 15); mram[2] = 'hE0; mram[3] = 'hF0;
    mram[14] = 28; mram[15] = 14;
    load_image();
    model_run(mc);
    run_prog(0, 0, nc, tmo);
    n_chk++; if (tmo) begin n_err++; $display("FAIL arith timeout: got no halt want halt"); end
    n_chk++; if (nc !== 21) begin n_err++; $display("FAIL arith cycles: got %0d want 21", nc); end
    n_chk++; if (got.size() != 1 || got[0] !== 42) begin n_err++; $display("FAIL arith out: got size %0d want single 42", got.size()); end
    n_chk++; if (pc !== 4'(m_pc)) begin n_err++; $display("FAIL arith pc: got %0d want %0d", pc, m_pc); end
    cmp_outs("arith");
  endtask

  task automatic test_sub_flags(input int x, input int y, input int first);
    int mc, nc; bit tmo;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(1, 14); mram[1] = enc(3, 15); mram[2] = 'hE0;
    mram[3] = enc(7, 8); mram[4] = enc(8, 10); mram[5] = enc(5, 1); mram[6] = 'hE0;
    mram[8] = enc(5, 2); mram[9] = 'hE0; mram[10] = enc(5, 3); mram[11] = 'hE0;
    mram[14] = x; mram[15] = y;
    load_image();
    model_run(mc);
    run_prog(0, 0, nc, tmo);
    n_chk++; if (tmo || nc !== mc) begin n_err++; $display("FAIL sub cycles: got %0d want %0d", nc, mc); end
    n_chk++; if (got.size() == 0 || got[0] !== first) begin n_err++; $display("FAIL sub result: got %0d want %0d", (got.size() ? got[0] : -1), first); end
    cmp_outs("sub_flags");
  endtask

  task automatic test_wrap();
    int mc, nc; bit tmo;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(1, 14); mram[1] = enc(2, 15); mram[2] = 'hE0; mram[3] = enc(7, 5);
    mram[5] = enc(5, 9); mram[6] = 'hE0; mram[14] = 200; mram[15] = 100;
    load_image();
    model_run(mc);
    run_prog(0, 0, nc, tmo);
    n_chk++; if (got.size() != 2 || got[0] !== 44 || got[1] !== 9) begin n_err++; $display("FAIL wrap add: got size %0d want 44 then 9", got.size()); end
    cmp_outs("wrap_add");
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'h00;
    mram[0] = enc(6, 15); mram[15] = 'hF0;
    load_image();
    model_run(mc);
    run_prog(0, 0, nc, tmo);
    n_chk++; if (tmo || pc !== 4'd0) begin n_err++; $display("FAIL pc wrap: got %0d want 0", pc); end
    n_chk++; if (nc !== mc) begin n_err++; $display("FAIL pc wrap cycles: got %0d want %0d", nc, mc); end
  endtask

  task automatic test_random();
    int mc, nc, k; bit tmo, rr;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        k = $urandom_range(0, 8);
        case (k)
          0: mram[i] = 0;
          1, 2, 3, 4: mram[i] = enc(k, $urandom_range(11, 15));
          5: mram[i] = enc(5, $urandom_range(0, 15));
          6: mram[i] = 'hE0;
          default: mram[i] = enc(k, $urandom_range(i + 1, 10));
        endcase
      end
      mram[10] = 'hF0;
      for (int i = 11; i < 16; i++) mram[i] = $urandom_range(0, 255);
      load_image();
      model_run(mc);
      rr = it[0];
      run_prog(rr, 0, nc, tmo);
      n_chk++; if (tmo) begin n_err++; $display("FAIL random %0d timeout: got no halt want halt", it); end
      if (!rr) begin
        n_chk++; if (nc !== mc) begin n_err++; $display("FAIL random %0d cycles: got %0d want %0d", it, nc, mc); end
      end
      n_chk++; if (pc !== 4'(m_pc)) begin n_err++; $display("FAIL random %0d pc: got %0d want %0d", it, pc, m_pc); end
      cmp_outs("random");
    end
  endtask

  task automatic test_backpressure();
    int n; logic [3:0] pc0;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(5, 7); mram[1] = 'hE0;
    load_image();
    out_ready = 1'b0; run = 1'b1;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    n_chk++; if (!out_valid) begin n_err++; $display("FAIL bp valid: got 0 want 1 within 20 cycles"); end
    pc0 = pc;
    for (int j = 0; j < 10; j++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 8'd7 || pc !== pc0) begin
        n_err++; $display("FAIL bp hold %0d: got v=%b d=%0d pc=%0d want v=1 d=7 pc=%0d", j, out_valid, out_data, pc, pc0);
      end
      tick();
    end
    out_ready = 1'b1;
    n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp release: got %b want 1", out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp drop: got %b want 0", out_valid); end
    n = 0;
    while (!halted && n < 20) begin tick(); n++; end
    n_chk++; if (!halted || pc !== 4'd3) begin n_err++; $display("FAIL bp end: got halted=%b pc=%0d want 1 3", halted, pc); end
    run = 1'b0; tick();
  endtask

  task automatic test_load_running();
    int mc, nc; bit tmo;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = (i < 8) ? 0 : 'hF0;
    mram[8] = enc(1, 15); mram[9] = 'hE0; mram[15] = 'h55;
    load_image();
    model_run(mc);
    run_prog(0, 1, nc, tmo);
    n_chk++; if (got.size() != 1 || got[0] !== 'h55) begin n_err++; $display("FAIL load while running: got size %0d want single 85", got.size()); end
    cmp_outs("load_running");
  endtask

  task automatic test_run_drop();
    int n, seen, nc; bit tmo;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(1, 14); mram[1] = enc(2, 15); mram[2] = 'hE0;
    mram[14] = 28; mram[15] = 14;
    load_image();
    run = 1'b1;
    tick();
    n = 0; seen = 0;
    while (n < 40) begin
      if (out_valid) seen++;
      tick(); n++;
      if (n == 8) run = 1'b0;
      if (halted) break;
    end
    n_chk++; if (!halted || n !== 14) begin n_err++; $display("FAIL run drop halt: got halted=%b at %0d want 1 at 14", halted, n); end
    n_chk++; if (pc !== 4'd2 || seen !== 0) begin n_err++; $display("FAIL run drop state: got pc=%0d outs=%0d want 2 0", pc, seen); end
    tick();
    run_prog(0, 0, nc, tmo);
    n_chk++; if (tmo || got.size() != 1 || got[0] !== 42) begin n_err++; $display("FAIL run resume: got size %0d want single 42", got.size()); end
  endtask

  task automatic test_reset_outwait();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 'hF0;
    mram[0] = enc(5, 9); mram[1] = 'hE0;
    load_image();
    out_ready = 1'b0; run = 1'b1;
    tick();
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    n_chk++; if (out_valid !== 1'b1 || out_data !== 8'd9) begin n_err++; $display("FAIL outwait entry: got v=%b d=%0d want 1 9", out_valid, out_data); end
    reset = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0 || pc !== 4'd0 || halted !== 1'b1) begin
      n_err++; $display("FAIL reset in outwait: got v=%b pc=%0d h=%b want 0 0 1", out_valid, pc, halted);
    end
    reset = 1'b0; run = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wide();
    int n, seen; logic [11:0] first;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w_we = 1'b1;
      case (i)
        0: begin w_addr = 8'd0;  w_wdata = 12'h10E; end
        1: begin w_addr = 8'd1;  w_wdata = 12'h20F; end
        2: begin w_addr = 8'd2;  w_wdata = 12'hE00; end
        3: begin w_addr = 8'd3;  w_wdata = 12'hF00; end
        4: begin w_addr = 8'd14; w_wdata = 12'd28;  end
        default: begin w_addr = 8'd15; w_wdata = 12'd14; end
      endcase
      tick();
    end
    w_we = 1'b0; w_run = 1'b1;
    tick();
    n = 0; seen = 0; first = '0;
    while (n < 60) begin
      if (w_valid) begin seen++; first = w_out; end
      tick(); n++;
      if (w_halted) break;
    end
    n_chk++; if (!w_halted || n !== 21) begin n_err++; $display("FAIL wide cycles: got %0d want 21", n); end
    n_chk++; if (seen !== 1 || first !== 12'd42) begin n_err++; $display("FAIL wide out: got %0d x%0d want 42 x1", first, seen); end
    w_run = 1'b0; tick();
  endtask

`ifdef EATER_CORE_STEP_EN
  task automatic test_step();
    int n;
    do_reset();
    for (int i = 0; i < 16; i++) mram[i] = 0;
    load_image();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      n_chk++; if (halted !== 1'b0) begin n_err++; $display("FAIL step %0d start: got halted=%b want 0", k, halted); end
      n = 0;
      while (!halted && n < 20) begin tick(); n++; end
      n_chk++; if (!halted || pc !== 4'(k + 1)) begin n_err++; $display("FAIL step %0d pc: got %0d want %0d", k, pc, k + 1); end
      repeat (2) tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_sub_flags(5, 5, 0);
    test_sub_flags(3, 5, 254);
    test_wrap();
    test_backpressure();
    test_load_running();
    test_run_drop();
    test_reset_outwait();
    test_wide();
    test_random();
`ifdef EATER_CORE_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
